// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches words from imem one at a time and buffers them for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2;
  logic [1:0] state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic drop, drop_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [63:0] mem [DEPTH];
  logic push, pop, credit, gnt_hs;
  assign imem_req   = state == REQ;
  assign imem_addr  = pc;
  assign inst_valid = count != '0;
  assign inst       = inst_valid ? mem[rd_ptr][63:32] : '0;
  assign inst_pc    = inst_valid ? mem[rd_ptr][31:0] : '0;
  // credit uses next-cycle occupancy so a fetch is raised only when its result is guaranteed a slot
  always_comb begin
    gnt_hs    = state == REQ && imem_gnt;
    push      = state == WAIT && imem_rvalid && !drop && !redirect;
    pop       = inst_valid && inst_ready && !redirect;
    count_nxt = redirect ? '0 : count + CW'(push) - CW'(pop);
    credit    = count_nxt < CW'(DEPTH);
    state_nxt = state == IDLE ? (credit ? REQ : IDLE) :
                state == REQ  ? (imem_gnt ? WAIT : redirect ? IDLE : REQ) :
                state == WAIT ? (imem_rvalid ? (credit ? REQ : IDLE) : WAIT) : IDLE;
    pc_nxt    = redirect ? redirect_pc & ~32'd3 : gnt_hs ? pc + 32'd4 : pc;
    drop_nxt  = redirect && (gnt_hs || (state == WAIT && !imem_rvalid)) ? 1'b1 :
                state == WAIT && imem_rvalid ? 1'b0 : drop;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      drop   <= 1'b0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      drop   <= drop_nxt;
      count  <= count_nxt;
      wr_ptr <= redirect ? '0 : wr_ptr + AW'(push);
      rd_ptr <= redirect ? '0 : rd_ptr + AW'(pop);
    end
  end
  // while a fetch is outstanding pc already points past it
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {imem_rdata, pc - 32'd4};
  end
endmodule
